// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a DEPTH-entry FIFO, issues one opcode/operand per clock; ALU_SEQ_STATS_EN adds issue/drop counters.
// Latency: one cycle from push to alu_opcode/alu_a on an empty unpaused FIFO; NOOP bubbles on empty, pause and MULT/DIV hold.
// Backpressure: cmd_ready = !full from registered occupancy, no pass-through when full.
module alu_cmd_sequencer #(
    parameter int DEPTH      = 8,
    parameter int DW         = 16,
    parameter int MULDIV_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_opcode,
    input  logic [DW-1:0]              cmd_operand,
    input  logic                       pause,
    output logic [3:0]                 alu_opcode,
    output logic [DW-1:0]              alu_a,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       illegal_drop
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]                issued_count,
    output logic [15:0]                dropped_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int HW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    logic [DW+3:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [3:0]      opc_q, opc_d;
    logic [DW-1:0]   a_q, a_d;
    logic            drop_q, drop_d;
    logic            push, pop;
    logic [3:0]      head_op;
    logic [DW-1:0]   head_a;

    assign empty        = (count_q == '0);
    assign full         = (count_q == LW'(DEPTH));
    assign cmd_ready    = !full;
    assign level        = count_q;
    assign alu_opcode   = opc_q;
    assign alu_a        = a_q;
    assign illegal_drop = drop_q;
    assign push         = cmd_valid && !full;
    assign {head_op, head_a} = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_opcode, cmd_operand};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // IDLE issues directly when data is present so a fresh push reaches the ALU one cycle later.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        opc_d   = 4'b0000;
        a_d     = '0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE, ISSUE: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = ISSUE;
                end else begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                    if (head_op <= 4'd9) begin
                        opc_d = head_op;
                        a_d   = head_a;
                        if ((head_op == 4'd4 || head_op == 4'd5) && MULDIV_LAT > 1) begin
                            hold_d  = HOLD_LOAD;
                            state_d = HOLD;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                hold_d = hold_q - HW'(1);
                if (hold_q <= HW'(1)) begin
                    state_d = empty ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            opc_q    <= 4'b0000;
            a_q      <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            drop_q   <= drop_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] issued_q, issued_d, dropped_q, dropped_d;

    always_comb begin
        issued_d  = issued_q;
        dropped_d = dropped_q;
        if (pop && !drop_d && issued_q != 16'hFFFF) begin
            issued_d = issued_q + 16'd1;
        end
        if (drop_d && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign issued_count  = issued_q;
    assign dropped_count = dropped_q;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: per-scenario tasks compare issued ALU slots against a queue of expected slots.
module tb_alu_cmd_sequencer;
    localparam int DEPTH  = 8;
    localparam int DW     = 16;
    localparam int TB_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = 4'd0;
    logic [DW-1:0] cmd_operand = '0;
    logic          pause = 1'b0;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [3:0]    level;
    logic          empty, full, illegal_drop;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]   issued_count, dropped_count;
`endif

    alu_cmd_sequencer #(.DEPTH(DEPTH), .DW(DW), .MULDIV_LAT(TB_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .pause(pause),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .level(level), .empty(empty),
        .full(full), .illegal_drop(illegal_drop)
`ifdef ALU_SEQ_STATS_EN
        , .issued_count(issued_count), .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic          drop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void expect_slot(input logic [3:0] op, input logic [DW-1:0] a, input logic drop);
        exp_t e;
        e.op = op; e.a = a; e.drop = drop;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [DW-1:0] a);
        cmd_valid   = v;
        cmd_opcode  = op;
        cmd_operand = a;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 4'd0, '0);
        pause = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({alu_opcode, alu_a, empty, cmd_ready, full, illegal_drop, level} !==
                {4'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: op=%h a=%h empty=%b rdy=%b full=%b drop=%b lvl=%0d, expected 0/0 empty=1 rdy=1 full=0 drop=0 lvl=0",
                         c, alu_opcode, alu_a, empty, cmd_ready, full, illegal_drop, level);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.delete();
        expect_slot(4'h0, 16'd0, 1'b0);
        expect_slot(4'h2, 16'd3, 1'b0);
        expect_slot(4'h3, 16'd1, 1'b0);
        expect_slot(4'h9, 16'd10, 1'b0);
        expect_slot(4'h0, 16'd0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_opcode, alu_a, illegal_drop} !== {e.op, e.a, e.drop}) begin
                    n_fail++;
                    $display("FAIL back_to_back cycle %0d: got op=%h a=%h drop=%b, expected op=%h a=%h drop=%b",
                             c, alu_opcode, alu_a, illegal_drop, e.op, e.a, e.drop);
                end
            end
            case (c)
                0: drive(1'b1, 4'h2, 16'd3);
                1: drive(1'b1, 4'h3, 16'd1);
                2: drive(1'b1, 4'h9, 16'd10);
                default: drive(1'b0, 4'h0, '0);
            endcase
        end
        n_checks++;
        if (level !== 4'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_drain: level=%0d empty=%b, expected level=0 empty=1", level, empty);
        end
    endtask

    task automatic test_muldiv();
        exp_t e;
        sb.delete();
        expect_slot(4'h0, 16'd0, 1'b0);
        expect_slot(4'h4, 16'd15, 1'b0);
        for (int i = 0; i < TB_LAT - 1; i++) expect_slot(4'h0, 16'd0, 1'b0);
        expect_slot(4'h6, 16'd15, 1'b0);
        expect_slot(4'h5, 16'd2, 1'b0);
        for (int i = 0; i < TB_LAT - 1; i++) expect_slot(4'h0, 16'd0, 1'b0);
        expect_slot(4'h9, 16'd1, 1'b0);
        expect_slot(4'h0, 16'd0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_opcode, alu_a, illegal_drop} !== {e.op, e.a, e.drop}) begin
                    n_fail++;
                    $display("FAIL muldiv cycle %0d: got op=%h a=%h drop=%b, expected op=%h a=%h drop=%b",
                             c, alu_opcode, alu_a, illegal_drop, e.op, e.a, e.drop);
                end
            end
            case (c)
                0: drive(1'b1, 4'h4, 16'd15);
                1: drive(1'b1, 4'h6, 16'd15);
                2: drive(1'b1, 4'h5, 16'd2);
                3: drive(1'b1, 4'h9, 16'd1);
                default: drive(1'b0, 4'h0, '0);
            endcase
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        sb.delete();
        expect_slot(4'h0, 16'd0, 1'b0);
        expect_slot(4'h2, 16'd1, 1'b0);
        expect_slot(4'h0, 16'd0, 1'b1);
        expect_slot(4'h7, 16'd7, 1'b0);
        expect_slot(4'h0, 16'd0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_opcode, alu_a, illegal_drop} !== {e.op, e.a, e.drop}) begin
                    n_fail++;
                    $display("FAIL illegal cycle %0d: got op=%h a=%h drop=%b, expected op=%h a=%h drop=%b",
                             c, alu_opcode, alu_a, illegal_drop, e.op, e.a, e.drop);
                end
            end
            case (c)
                0: drive(1'b1, 4'h2, 16'd1);
                1: drive(1'b1, 4'hC, 16'd7);
                2: drive(1'b1, 4'h7, 16'd7);
                default: drive(1'b0, 4'h0, '0);
            endcase
        end
    endtask

    task automatic test_full_pause();
        exp_t          e;
        logic [3:0]    ops [8];
        logic [DW-1:0] args [8];
        ops  = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'h2};
        args = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
        sb.delete();
        for (int i = 0; i < 9; i++) expect_slot(4'h0, 16'd0, 1'b0);
        for (int i = 0; i < 8; i++) expect_slot(ops[i], args[i], 1'b0);
        expect_slot(4'h0, 16'd0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c > 0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({alu_opcode, alu_a, illegal_drop} !== {e.op, e.a, e.drop}) begin
                    n_fail++;
                    $display("FAIL full_pause cycle %0d: got op=%h a=%h drop=%b, expected op=%h a=%h drop=%b",
                             c, alu_opcode, alu_a, illegal_drop, e.op, e.a, e.drop);
                end
            end
            if (c == 8 || c == 9) begin
                n_checks++;
                if ({full, cmd_ready, level} !== {1'b1, 1'b0, 4'd8}) begin
                    n_fail++;
                    $display("FAIL full_flags cycle %0d: full=%b rdy=%b lvl=%0d, expected full=1 rdy=0 lvl=8",
                             c, full, cmd_ready, level);
                end
            end
            if (c < 8) begin
                pause = 1'b1;
                drive(1'b1, ops[c], args[c]);
            end else if (c == 8) begin
                pause = 1'b1;
                drive(1'b1, 4'h3, 16'hBEEF);
            end else begin
                pause = 1'b0;
                drive(1'b0, 4'h0, '0);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            case (c)
                0: begin pause = 1'b1; drive(1'b1, 4'h4, 16'd5); end
                1, 2, 3, 4, 5: drive(1'b1, 4'h2, DW'(c));
                default: begin pause = 1'b0; drive(1'b0, 4'h0, '0); end
            endcase
        end
        @(negedge clk);
        n_checks++;
        if ({alu_opcode, alu_a, level} !== {4'h4, 16'd5, 4'd5}) begin
            n_fail++;
            $display("FAIL pre_reset_hold: op=%h a=%h lvl=%0d, expected op=4 a=0005 lvl=5", alu_opcode, alu_a, level);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({alu_opcode, alu_a, level, empty, full, cmd_ready} !== {4'h0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: op=%h a=%h lvl=%0d empty=%b full=%b rdy=%b, expected 0/0 lvl=0 empty=1 full=0 rdy=1",
                     alu_opcode, alu_a, level, empty, full, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({alu_opcode, alu_a, level, illegal_drop} !== {4'h0, 16'd0, 4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL post_reset_quiet cycle %0d: op=%h a=%h lvl=%0d drop=%b, expected 0/0 lvl=0 drop=0",
                         c, alu_opcode, alu_a, level, illegal_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_muldiv();
        test_illegal();
        test_full_pause();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
